exe_div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the execute stage. It accepts a DIV/DIVU from EX, runs a 32-iteration radix-2 restoring divide, and holds the EX/MEM register with a stall until the result is ready. It then presents the 64-bit {HI,LO} result with a one-cycle finish pulse that the EX/MEM register consumes. Interrupt/exception flush aborts an in-flight divide.

---
 rtl/exe_div_ctrl.sv | 147 ++++++++++++++
 tb/tb_exe_div_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: multi-cycle divide sequencer for the execute stage.
// It runs a 32-step radix-2 restoring divide on operand magnitudes and then
// applies sign fixups. While the divide is pending it stalls EX/MEM and the
// earlier stages. The result is then held in DONE for as long as pipe_hold
// keeps EX/MEM from advancing.
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   div_req, div_signed  DIV/DIVU request from EX (level) and signedness
//   div_opa, div_opb     dividend / divisor, sampled when the request is accepted
//   int_flush            exception/ERET flush; aborts any divide in flight
//   pipe_hold            downstream stall; keeps a finished result in DONE
//   div_stall            combinational stall to EX/MEM and the earlier stages
//   div_finish           registered one-cycle (or held) result-valid strobe
//   hilo_out             registered {HI = remainder, LO = quotient}
module exe_div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_opa,
  input  logic [31:0] div_opb,
  input  logic        int_flush,
  input  logic        pipe_hold,
  output logic        div_stall,
  output logic        div_finish,
  output logic [63:0] hilo_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        fin_q, fin_d;
  logic [63:0] hilo_q, hilo_d;

  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] step_rem, step_quo;
  logic [31:0] opa_mag, opb_mag;

  // One restoring step. The trial remainder is 33 bits wide, so the compare
  // and subtract never overflow.
  always_comb begin
    trial    = {rem_q, dvd_q[31]};
    diff     = trial - {1'b0, dvs_q};
    take     = (trial >= {1'b0, dvs_q});
    step_rem = take ? diff[31:0] : trial[31:0];
    step_quo = {dvd_q[30:0], take};
  end

  // The magnitude of 0x80000000 wraps back to 0x80000000. That is the
  // correct unsigned magnitude.
  always_comb begin
    opa_mag = (div_signed && div_opa[31]) ? (32'd0 - div_opa) : div_opa;
    opb_mag = (div_signed && div_opb[31]) ? (32'd0 - div_opb) : div_opb;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    fin_d   = fin_q;
    hilo_d  = hilo_q;
    case (state_q)
      S_IDLE: begin
        fin_d = 1'b0;
        if (div_req) begin
          dvd_d   = opa_mag;
          dvs_d   = opb_mag;
          rem_d   = '0;
          qneg_d  = div_signed & (div_opa[31] ^ div_opb[31]);
          rneg_d  = div_signed & div_opa[31];
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        dvd_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
          hilo_d  = {rneg_q ? (32'd0 - step_rem) : step_rem,
                     qneg_q ? (32'd0 - step_quo) : step_quo};
        end
      end
      S_DONE: begin
        if (!pipe_hold) begin
          state_d = S_IDLE;
          fin_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        fin_d   = 1'b0;
      end
    endcase
    // A flush overrides everything above. It also blocks a same-cycle accept
    // from reaching BUSY. Any working registers loaded here are don't-care.
    if (int_flush) begin
      state_d = S_IDLE;
      fin_d   = 1'b0;
      hilo_d  = hilo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      fin_q   <= 1'b0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      fin_q   <= fin_d;
      hilo_q  <= hilo_d;
    end
  end

  // Stall is low in DONE, so the instruction leaves EX together with the finish pulse.
  assign div_stall  = resetn & ~int_flush &
                      (((state_q == S_IDLE) & div_req) | (state_q == S_BUSY));
  assign div_finish = fin_q;
  assign hilo_out   = hilo_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl. It runs directed vectors (signed and
// unsigned, divide by zero, flush, hold, back-to-back, mid-divide reset) and
// then randomized divides that are checked against an arithmetic reference.
module tb_exe_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        int_flush;
  logic        pipe_hold;
  logic        div_stall;
  logic        div_finish;
  logic [63:0] hilo_out;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [63:0] last_exp;

  exe_div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_req    (div_req),
    .div_signed (div_signed),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .int_flush  (int_flush),
    .pipe_hold  (pipe_hold),
    .div_stall  (div_stall),
    .div_finish (div_finish),
    .hilo_out   (hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: divide the magnitudes, negate the quotient when the
  // operand signs differ, and give the remainder the sign of the dividend.
  // Division by zero yields an all-ones quotient and the dividend as the remainder.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ua, ub, q, r;
    ua = (sg && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    ub = (sg && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    if (ub == 64'd0) begin
      q = 64'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sg && (a[31] ^ b[31])) q = (64'h1_0000_0000 - q) & 64'hFFFF_FFFF;
    if (sg && a[31])           r = (64'h1_0000_0000 - r) & 64'hFFFF_FFFF;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge while the DUT is IDLE. The call returns at the negedge
  // of the IDLE cycle that follows DONE, so a following call is back-to-back.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [63:0] exp);
    div_signed = sg;
    div_opa    = a;
    div_opb    = b;
    div_req    = 1'b1;
    #1;
    chk("stall_accept", 64'(div_stall), 64'd1);
    chk("fin_accept", 64'(div_finish), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      // Operands must not be resampled while the divide is running.
      div_opa    = $urandom;
      div_opb    = $urandom;
      div_signed = 1'($urandom_range(0, 1));
      if (i == 32) pipe_hold = (hold > 0);
      #1;
      chk("stall_busy", 64'(div_stall), 64'd1);
      chk("fin_busy", 64'(div_finish), 64'd0);
    end
    @(negedge clk);
    div_req = 1'b0;
    #1;
    chk("fin_done", 64'(div_finish), 64'd1);
    chk("stall_done", 64'(div_stall), 64'd0);
    chk("hilo_done", hilo_out, exp);
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      pipe_hold = (k < hold);
      #1;
      chk("fin_held", 64'(div_finish), 64'd1);
      chk("hilo_held", hilo_out, exp);
    end
    @(negedge clk);
    pipe_hold = 1'b0;
    #1;
    chk("fin_after", 64'(div_finish), 64'd0);
    chk("stall_after", 64'(div_stall), 64'd0);
    chk("hilo_after", hilo_out, exp);
    last_exp = exp;
  endtask

  initial begin
    logic        sg;
    logic [31:0] a, b;

    resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0; div_opa = '0; div_opb = '0;
    int_flush = 1'b0; pipe_hold = 1'b0;
    repeat (2) @(negedge clk);
    div_req = 1'b1;
    #1;
    chk("stall_in_reset", 64'(div_stall), 64'd0);
    chk("fin_reset", 64'(div_finish), 64'd0);
    chk("hilo_reset", hilo_out, 64'd0);
    div_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_div(1'b0, 32'd100,        32'd7,        0, 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,        0, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 0, 64'h00000000_80000000);
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,        0, 64'h00000000_FFFFFFFF);
    run_div(1'b0, 32'd5,          32'd0,        0, 64'h00000005_FFFFFFFF);
    run_div(1'b1, 32'hFFFFFFFB,   32'd0,        0, 64'hFFFFFFFB_00000001);

    // Flush during BUSY at cycle A+10.
    div_signed = 1'b0; div_opa = 32'd12345; div_opb = 32'd7; div_req = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    int_flush = 1'b1;
    #1;
    chk("stall_flush", 64'(div_stall), 64'd0);
    @(negedge clk);
    int_flush = 1'b0;
    div_req   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("fin_flushed", 64'(div_finish), 64'd0);
      chk("hilo_flushed", hilo_out, last_exp);
      @(negedge clk);
    end
    run_div(1'b0, 32'd9, 32'd3, 0, 64'h00000000_00000003);

    // A 3-cycle hold in DONE, followed by a back-to-back second divide.
    run_div(1'b0, 32'd1000, 32'd33,        3, 64'h0000000A_0000001E);
    run_div(1'b1, 32'd7,    32'hFFFFFFFE,  0, 64'h00000001_FFFFFFFD);

    // Reset asserted mid-BUSY.
    div_signed = 1'b0; div_opa = 32'd1000; div_opb = 32'd3; div_req = 1'b1;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("fin_midreset", 64'(div_finish), 64'd0);
    chk("hilo_midreset", hilo_out, 64'd0);
    chk("stall_midreset", 64'(div_stall), 64'd0);
    resetn  = 1'b1;
    div_req = 1'b0;
    @(negedge clk);
    #1;
    chk("stall_post_reset", 64'(div_stall), 64'd0);
    last_exp = 64'd0;

    for (int n = 0; n < 20; n++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 32'h80000000;
        1:       a = 32'($urandom_range(0, 50));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_div(sg, a, b, int'($urandom_range(0, 2)), ref_div(sg, a, b));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
